// File: rtl/perceptron_accumulate_controller.sv
// Perceptron pre-activation accumulator: bias + N_TERMS sign-magnitude Q16.15 terms,
// summed through one shared sign-magnitude adder with saturation and -0 normalisation.
module perceptron_accumulate_controller #(
  parameter int SIGN    = 1,
  parameter int Q_M     = 16,
  parameter int Q_N     = 15,
  parameter int N_TERMS = 4,
  localparam int W      = SIGN + Q_M + Q_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bias_in,
  input  logic         term_valid,
  output logic         term_ready,
  input  logic [W-1:0] term_data,
  output logic         sum_valid,
  input  logic         sum_ready,
  output logic [W-1:0] sum_out,
  output logic         overflow,
  output logic         busy
);

  localparam int CW = $clog2(N_TERMS + 1);

  // Handshakes: a term transfers on a rising edge where term_valid && term_ready;
  // the result transfers on a rising edge where sum_valid && sum_ready.
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  acc;
  logic [CW-1:0] count;
  logic [W:0]    add_res;
  logic          mag_carry;
  logic [W-1:0]  acc_next;
  logic          term_fire;
  logic          last_term;

  // Shared sign-magnitude adder. Bit W is the carry out of the W-bit magnitude sum,
  // only meaningful when operand signs match (opposite signs cannot overflow).
  function automatic logic [W:0] add_sm(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-2:0] am, bm;
    logic [W-1:0] m_sum;
    am    = a[W-2:0];
    bm    = b[W-2:0];
    m_sum = {1'b0, am} + {1'b0, bm};
    if (a[W-1] == b[W-1])
      add_sm = {m_sum[W-1], a[W-1], m_sum[W-2:0]};
    else if (am >= bm)
      add_sm = {1'b0, a[W-1], am - bm};
    else
      add_sm = {1'b0, b[W-1], bm - am};
  endfunction

  function automatic logic [W-1:0] norm_zero(input logic [W-1:0] x);
    norm_zero = (x[W-2:0] == '0) ? '0 : x;
  endfunction

  assign add_res   = add_sm(acc, term_data);
  assign mag_carry = add_res[W];
  assign acc_next  = mag_carry ? {acc[W-1], {(W-1){1'b1}}} : norm_zero(add_res[W-1:0]);
  assign term_fire = term_valid && term_ready;
  assign last_term = (count == CW'(N_TERMS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        acc      <= norm_zero(bias_in);
        count    <= '0;
        overflow <= 1'b0;
      end else if (term_fire) begin
        acc   <= acc_next;
        count <= count + CW'(1);
        if (mag_carry) overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    term_ready = 1'b0;
    sum_valid  = 1'b0;
    sum_out    = '0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        term_ready = 1'b1;
        if (term_valid && last_term) state_next = DONE;
      end
      DONE: begin
        sum_valid = 1'b1;
        sum_out   = acc;
        if (sum_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_perceptron_accumulate_controller.sv
// Bench for perceptron_accumulate_controller with N_TERMS=3: directed scenarios plus
// randomized operations checked against a signed-integer reference model.
module tb_perceptron_accumulate_controller;

  localparam int W = 32;
  localparam int N = 3;
  localparam longint MAXMAG = 64'h7FFF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] bias_in;
  logic         term_valid;
  logic         term_ready;
  logic [W-1:0] term_data;
  logic         sum_valid;
  logic         sum_ready;
  logic [W-1:0] sum_out;
  logic         overflow;
  logic         busy;

  int tests = 0;
  int fails = 0;

  perceptron_accumulate_controller #(.SIGN(1), .Q_M(16), .Q_N(15), .N_TERMS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
    .term_valid(term_valid), .term_ready(term_ready), .term_data(term_data),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_out(sum_out),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: operands as signed integers; same-sign sums beyond the magnitude range
  // clamp to the largest magnitude of that sign and raise the sticky flag.
  function automatic void model_step(inout logic [W-1:0] acc, inout logic ovf,
                                     input logic [W-1:0] t);
    longint am, tm, av, tv, r;
    am = longint'(acc[W-2:0]);
    tm = longint'(t[W-2:0]);
    av = acc[W-1] ? -am : am;
    tv = t[W-1] ? -tm : tm;
    if (acc[W-1] == t[W-1] && am + tm > MAXMAG) begin
      acc = {acc[W-1], 31'h7FFF_FFFF};
      ovf = 1'b1;
    end else begin
      r   = av + tv;
      acc = (r < 0) ? {1'b1, 31'(-r)} : {1'b0, 31'(r)};
    end
  endfunction

  function automatic void model_op(input logic [W-1:0] bias, input logic [W-1:0] t0,
                                   input logic [W-1:0] t1, input logic [W-1:0] t2,
                                   output logic [W-1:0] s, output logic ovf);
    s   = (bias[W-2:0] == '0) ? '0 : bias;
    ovf = 1'b0;
    model_step(s, ovf, t0);
    model_step(s, ovf, t1);
    model_step(s, ovf, t2);
  endfunction

  // Driver: one full operation, optional random term_valid gaps (garbage data during gaps),
  // then holds sum_ready low for ready_delay cycles before accepting the result.
  task automatic run_op(input logic [W-1:0] bias, input logic [W-1:0] t0,
                        input logic [W-1:0] t1, input logic [W-1:0] t2,
                        input bit gaps, input int ready_delay,
                        output logic [W-1:0] got, output logic got_ovf,
                        output int cycles, output bit timeout);
    logic [W-1:0] tv[3];
    int idx;
    tv[0] = t0; tv[1] = t1; tv[2] = t2;
    start = 1'b1; bias_in = bias;
    tick();
    start = 1'b0; bias_in = $urandom;
    cycles = 1; idx = 0; timeout = 1'b0;
    while (idx < N && cycles < 60) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        term_valid = 1'b0; term_data = $urandom;
      end else begin
        term_valid = 1'b1; term_data = tv[idx];
      end
      if (term_valid && term_ready) idx++;
      tick();
      cycles++;
    end
    term_valid = 1'b0;
    while (!sum_valid && cycles < 60) begin
      tick();
      cycles++;
    end
    if (!sum_valid) timeout = 1'b1;
    got = sum_out;
    got_ovf = overflow;
    repeat (ready_delay) tick();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests++;
    if ({term_ready, sum_valid, overflow, busy} !== 4'b0000 || sum_out !== '0) begin
      fails++;
      $display("FAIL reset: ready/valid/ovf/busy=%b sum=%h expected 0000 / 00000000",
               {term_ready, sum_valid, overflow, busy}, sum_out);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] got; logic ov; int cyc; bit to;
    run_op(32'h0000_4000, 32'h0000_8000, 32'h0001_0000, 32'h8000_2000, 1'b0, 0, got, ov, cyc, to);
    tests++;
    if (to || cyc !== N + 1) begin
      fails++; $display("FAIL basic_latency: got %0d cycles (timeout=%0d) expected %0d", cyc, to, N + 1);
    end
    tests++;
    if (got !== 32'h0001_A000 || ov !== 1'b0) begin
      fails++; $display("FAIL basic_sum: got %h ovf %b expected 0001a000 ovf 0", got, ov);
    end
    tests++;
    if (busy !== 1'b0 || sum_valid !== 1'b0) begin
      fails++; $display("FAIL basic_idle: busy %b sum_valid %b expected 0 0", busy, sum_valid);
    end
  endtask

  task automatic test_cancel();
    logic [W-1:0] got; logic ov; int cyc; bit to;
    run_op(32'h0000_8000, 32'h8000_8000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1, got, ov, cyc, to);
    tests++;
    if (to || got !== 32'h0000_0000 || ov !== 1'b0) begin
      fails++; $display("FAIL cancel_zero: got %h ovf %b to %0d expected 00000000 ovf 0", got, ov, to);
    end
    run_op(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, got, ov, cyc, to);
    tests++;
    if (to || got !== 32'h0000_0000) begin
      fails++; $display("FAIL neg_zero_bias: got %h expected 00000000", got);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] got; logic ov; int cyc; bit to;
    start = 1'b1; bias_in = 32'h7FFF_FFFF;
    tick();
    start = 1'b0;
    term_valid = 1'b1; term_data = 32'h0000_0001;
    tick();
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL sat_flag_pos: got %b expected 1", overflow);
    end
    term_data = 32'h8000_0001; tick();
    term_data = 32'h0000_0000; tick();
    term_valid = 1'b0;
    tests++;
    if (sum_valid !== 1'b1 || sum_out !== 32'h7FFF_FFFE || overflow !== 1'b1) begin
      fails++; $display("FAIL sat_final_pos: valid %b sum %h ovf %b expected 1 7ffffffe 1",
                        sum_valid, sum_out, overflow);
    end
    sum_ready = 1'b1; tick(); sum_ready = 1'b0;
    run_op(32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 0, got, ov, cyc, to);
    tests++;
    if (to || got !== 32'hFFFF_FFFE || ov !== 1'b1) begin
      fails++; $display("FAIL sat_final_neg: got %h ovf %b expected fffffffe ovf 1", got, ov);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] tv[3];
    logic [W-1:0] exp_s; logic exp_o;
    bit pattern[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int idx;
    bit bad;
    for (int i = 0; i < 3; i++) tv[i] = {1'($urandom), 3'b0, 28'($urandom)};
    model_op(32'h0001_0000, tv[0], tv[1], tv[2], exp_s, exp_o);
    start = 1'b1; bias_in = 32'h0001_0000;
    tick();
    start = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      term_valid = pattern[i];
      term_data = pattern[i] ? tv[idx] : $urandom;
      if (pattern[i]) idx++;
      tick();
    end
    term_valid = 1'b0;
    tests++;
    if (sum_valid !== 1'b1 || sum_out !== exp_s || overflow !== exp_o) begin
      fails++; $display("FAIL gaps_sum: valid %b sum %h ovf %b expected 1 %h %b",
                        sum_valid, sum_out, overflow, exp_s, exp_o);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      term_valid = (i == 3);
      term_data = 32'h0000_8000;
      tick();
      if (sum_valid !== 1'b1 || sum_out !== exp_s || term_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    start = 1'b0; term_valid = 1'b0;
    tests++;
    if (bad) begin
      fails++; $display("FAIL hold_stable: sum %h valid %b ready %b expected %h 1 0",
                        sum_out, sum_valid, term_ready, exp_s);
    end
    // start coincident with the DONE->IDLE handshake must be ignored
    sum_ready = 1'b1; start = 1'b1;
    tick();
    sum_ready = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b0 || sum_valid !== 1'b0 || overflow !== exp_o) begin
      fails++; $display("FAIL release_idle: busy %b valid %b ovf %b expected 0 0 %b",
                        busy, sum_valid, overflow, exp_o);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL start_not_queued: busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got; logic ov; int cyc; bit to;
    start = 1'b1; bias_in = 32'h7FFF_FFFF;
    tick();
    start = 1'b0;
    term_valid = 1'b1; term_data = 32'h0000_0001;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({term_ready, sum_valid, overflow, busy} !== 4'b0000 || sum_out !== '0) begin
      fails++; $display("FAIL reset_mid: ready/valid/ovf/busy=%b sum=%h expected 0000 / 00000000",
                        {term_ready, sum_valid, overflow, busy}, sum_out);
    end
    term_valid = 1'b0;
    tick();
    run_op(32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 1'b0, 0, got, ov, cyc, to);
    tests++;
    if (to || got !== 32'h0002_0000 || ov !== 1'b0) begin
      fails++; $display("FAIL after_reset_sum: got %h ovf %b expected 00020000 ovf 0", got, ov);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got; logic ov; int cyc; bit to;
    run_op(32'h8000_0005, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0, got, ov, cyc, to);
    tests++;
    if (to || got !== 32'hFFFF_FFFE || ov !== 1'b1) begin
      fails++; $display("FAIL b2b_first: got %h ovf %b expected fffffffe ovf 1", got, ov);
    end
    tests++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_ovf_hold: ovf %b busy %b expected 1 0", overflow, busy);
    end
    run_op(32'h0000_0100, 32'h0000_0200, 32'h8000_0400, 32'h0000_0050, 1'b0, 0, got, ov, cyc, to);
    tests++;
    if (to || got !== 32'h8000_00B0 || ov !== 1'b0 || cyc !== N + 1) begin
      fails++; $display("FAIL b2b_second: got %h ovf %b cyc %0d expected 800000b0 ovf 0 cyc %0d",
                        got, ov, cyc, N + 1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] b, t0, t1, t2, got, exp_s;
    logic ov, exp_o;
    int cyc; bit to;
    for (int k = 0; k < 24; k++) begin
      b  = {1'($urandom), 31'($urandom >> $urandom_range(1, 31))};
      t0 = {1'($urandom), 31'($urandom >> $urandom_range(1, 31))};
      t1 = {1'($urandom), 31'($urandom >> $urandom_range(1, 31))};
      t2 = {1'($urandom), 31'($urandom >> $urandom_range(1, 31))};
      if (k % 6 == 0) t2 = {t1[W-1], 31'h7FFF_FFF0};
      model_op(b, t0, t1, t2, exp_s, exp_o);
      run_op(b, t0, t1, t2, 1'b1, $urandom_range(0, 3), got, ov, cyc, to);
      tests++;
      if (to || got !== exp_s || ov !== exp_o) begin
        fails++; $display("FAIL random_%0d: got %h ovf %b to %0d expected %h ovf %b",
                          k, got, ov, to, exp_s, exp_o);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias_in = '0; term_valid = 1'b0;
    term_data = '0; sum_ready = 1'b0;
    test_reset();
    test_basic();
    test_cancel();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
